// File: rtl/shift_register_ctrl.sv
// shift_register_ctrl
//   Sequencer and round-robin arbiter for an external WIDTH-bit parallel-load
//   shift register. One requester word is granted per frame. The word is loaded
//   into the register and then streamed MSB-first to a serial sink that can
//   apply backpressure. Each frame is tagged with its source id and a last-bit
//   marker.
//
// Ports
//   clk, reset_n      clock (rising edge), asynchronous active-low reset
//   req_valid/ready   per-requester handshake; ready is one-hot, IDLE only
//   req_data          requester i word at [i*WIDTH +: WIDTH]
//   sr_load/sr_shift  load / shift enables for the external shift register
//   sr_data_in        parallel word for the external shift register
//   sr_msb            current MSB of the external shift register
//   ser_bit/valid/ready/last/id   serial stream toward the sink
//   busy              high while a frame or its trailing gap is in progress
module shift_register_ctrl #(
  parameter int WIDTH      = 8,
  parameter int NREQ       = 2,
  parameter int GAP_CYCLES = 0,
  localparam int ID_W      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  sr_load,
  output logic                  sr_shift,
  output logic [WIDTH-1:0]      sr_data_in,
  input  logic                  sr_msb,
  output logic                  ser_bit,
  output logic                  ser_valid,
  input  logic                  ser_ready,
  output logic                  ser_last,
  output logic [ID_W-1:0]       ser_id,
  output logic                  busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic [3:0]       gap_cnt;
  logic [ID_W-1:0]  rr_ptr;
  logic [WIDTH-1:0] data_hold;

  logic [2*NREQ-1:0] dbl_valid;
  logic [NREQ-1:0]   rot_valid;
  logic              gnt_found;
  logic [ID_W-1:0]   gnt_off;
  logic [ID_W:0]     gnt_sum;
  logic [ID_W-1:0]   gnt_idx;
  logic [ID_W-1:0]   rr_next;
  logic              grant;
  logic [WIDTH-1:0]  gnt_data;
  logic              bit_last;

  // Round-robin search: rotate the request vector so rr_ptr sits at bit 0,
  // take the first set bit, then rotate the offset back to an absolute index.
  always_comb begin
    dbl_valid = {req_valid, req_valid} >> rr_ptr;
    rot_valid = dbl_valid[NREQ-1:0];
    gnt_found = 1'b0;
    gnt_off   = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (!gnt_found && rot_valid[j]) begin
        gnt_found = 1'b1;
        gnt_off   = ID_W'(j);
      end
    end
    gnt_sum = {1'b0, rr_ptr} + {1'b0, gnt_off};
    if (gnt_sum >= (ID_W+1)'(NREQ)) begin
      gnt_sum = gnt_sum - (ID_W+1)'(NREQ);
    end
    gnt_idx = gnt_sum[ID_W-1:0];
    if ({1'b0, gnt_idx} == (ID_W+1)'(NREQ - 1)) begin
      rr_next = '0;
    end else begin
      rr_next = gnt_idx + 1'b1;
    end
  end

  // The grant is combinational; gating with reset_n keeps every handshake
  // output quiet while reset is held even if requests are pending.
  assign grant = reset_n && (state == IDLE) && gnt_found;

  always_comb begin
    req_ready = '0;
    gnt_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == ID_W'(i)) begin
        req_ready[i] = grant;
        gnt_data     = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign bit_last   = (bit_cnt == LAST_BIT);
  assign sr_load    = grant;
  // Between grants the register input keeps the last loaded word.
  assign sr_data_in = grant ? gnt_data : data_hold;
  assign ser_valid  = (state == SHIFT);
  assign ser_bit    = ser_valid & sr_msb;
  assign ser_last   = ser_valid & bit_last;
  assign sr_shift   = ser_valid & ser_ready;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      rr_ptr    <= '0;
      ser_id    <= '0;
      data_hold <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            ser_id    <= gnt_idx;
            rr_ptr    <= rr_next;
            bit_cnt   <= '0;
            data_hold <= gnt_data;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          // A stalled sink freezes the counter, so ser_bit/ser_last hold too.
          if (ser_ready) begin
            if (bit_last) begin
              bit_cnt <= '0;
              if (GAP_CYCLES > 0) begin
                gap_cnt <= 4'(GAP_CYCLES - 1);
                state   <= GAP;
              end else begin
                state <= IDLE;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_register_ctrl.sv
// Bench for shift_register_ctrl: two instances (no gap, 3-cycle gap) share the
// stimulus; each drives its own bench-side shift register. A frame-level
// reference model predicts every output on every cycle.
module tb_shift_register_ctrl;

  localparam int W    = 8;
  localparam int N    = 2;
  localparam int IDW  = 1;
  localparam int GAP0 = 0;
  localparam int GAP1 = 3;
  localparam int BW   = N + W + IDW + 6;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [N-1:0]         req_valid;
  logic [N*W-1:0]       req_data;
  logic                 ser_ready;
  logic [1:0][N-1:0]    req_ready;
  logic [1:0]           sr_load, sr_shift, sr_msb, ser_bit, ser_valid, ser_last, busy;
  logic [1:0][W-1:0]    sr_data_in;
  logic [1:0][IDW-1:0]  ser_id;
  logic [W-1:0]         sr_reg [2];

  int checks = 0;
  int errors = 0;

  // model state, per instance
  int           m_mode [2];   // 0 idle, 1 streaming, 2 gap
  int           m_pos  [2];
  int           m_gap  [2];
  int           m_rr   [2];
  logic [W-1:0] m_word [2];
  logic [W-1:0] m_hold [2];
  logic [IDW-1:0] m_src [2];
  logic [W-1:0] acc    [2];

  // logs of observed frames and load cycles (ring of 64)
  int           fcount [2];
  int           fid    [2][64];
  logic [W-1:0] fword  [2][64];
  int           lcount [2];
  int           lcyc   [2][64];

  always #5 clk = ~clk;

  shift_register_ctrl #(.WIDTH(W), .NREQ(N), .GAP_CYCLES(GAP0)) dut0 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready[0]), .sr_load(sr_load[0]), .sr_shift(sr_shift[0]),
    .sr_data_in(sr_data_in[0]), .sr_msb(sr_msb[0]), .ser_bit(ser_bit[0]),
    .ser_valid(ser_valid[0]), .ser_ready(ser_ready), .ser_last(ser_last[0]),
    .ser_id(ser_id[0]), .busy(busy[0])
  );

  shift_register_ctrl #(.WIDTH(W), .NREQ(N), .GAP_CYCLES(GAP1)) dut3 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready[1]), .sr_load(sr_load[1]), .sr_shift(sr_shift[1]),
    .sr_data_in(sr_data_in[1]), .sr_msb(sr_msb[1]), .ser_bit(ser_bit[1]),
    .ser_valid(ser_valid[1]), .ser_ready(ser_ready), .ser_last(ser_last[1]),
    .ser_id(ser_id[1]), .busy(busy[1])
  );

  // external shift registers
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (sr_load[d]) sr_reg[d] <= sr_data_in[d];
      else if (sr_shift[d]) sr_reg[d] <= {sr_reg[d][W-2:0], 1'b0};
    end
  end
  assign sr_msb[0] = sr_reg[0][W-1];
  assign sr_msb[1] = sr_reg[1][W-1];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input int d);
    int           g, c, gp;
    bit           found;
    logic [W-1:0] w;
    logic [N-1:0] e_ready;
    logic         e_load, e_shift, e_bit, e_valid, e_last, e_busy;
    logic [W-1:0] e_data;
    logic [IDW-1:0] e_id;
    logic [BW-1:0] expv, actv;
    gp = (d == 0) ? GAP0 : GAP1;
    if (sr_load[d]) begin
      lcyc[d][lcount[d] % 64] = int'($time / 10);
      lcount[d]++;
    end
    actv = {req_ready[d], sr_load[d], sr_shift[d], sr_data_in[d], ser_bit[d],
            ser_valid[d], ser_last[d], ser_id[d], busy[d]};
    if (!reset_n) begin
      expv      = '0;
      m_mode[d] = 0;
      m_rr[d]   = 0;
      m_hold[d] = '0;
      m_src[d]  = '0;
    end else begin
      e_ready = '0; e_load = 1'b0; e_shift = 1'b0; e_bit = 1'b0;
      e_valid = 1'b0; e_last = 1'b0;
      e_data  = m_hold[d];
      e_id    = m_src[d];
      e_busy  = (m_mode[d] != 0);
      case (m_mode[d])
        0: begin
          found = 1'b0; g = 0;
          for (int k = 0; k < N; k++) begin
            c = (m_rr[d] + k) % N;
            if (!found && (((req_valid >> c) & 1) != 0)) begin
              found = 1'b1; g = c;
            end
          end
          if (found) begin
            w         = W'(req_data >> (g * W));
            e_ready   = N'(1) << g;
            e_load    = 1'b1;
            e_data    = w;
            m_mode[d] = 1;
            m_word[d] = w;
            m_pos[d]  = 0;
            m_src[d]  = IDW'(g);
            m_rr[d]   = (g + 1) % N;
            m_hold[d] = w;
          end
        end
        1: begin
          e_valid = 1'b1;
          e_bit   = 1'(m_word[d] >> (W - 1 - m_pos[d]));
          e_last  = (m_pos[d] == W - 1);
          e_shift = ser_ready;
          if (ser_ready) begin
            acc[d] = {acc[d][W-2:0], ser_bit[d]};
            m_pos[d]++;
            if (m_pos[d] == W) begin
              fid[d][fcount[d] % 64]   = int'(ser_id[d]);
              fword[d][fcount[d] % 64] = acc[d];
              fcount[d]++;
              if (gp > 0) begin
                m_mode[d] = 2; m_gap[d] = gp;
              end else begin
                m_mode[d] = 0;
              end
            end
          end
        end
        default: begin
          m_gap[d]--;
          if (m_gap[d] == 0) m_mode[d] = 0;
        end
      endcase
      expv = {e_ready, e_load, e_shift, e_data, e_bit, e_valid, e_last, e_id, e_busy};
    end
    checks++;
    if (actv !== expv) begin
      errors++;
      $display("FAIL model_dut%0d at %0t: got %h expected %h", d, $time, actv, expv);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      model_step(0);
      model_step(1);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((busy != 2'b00 || m_mode[0] != 0 || m_mode[1] != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(n < 300), 32'd1);
  endtask

  int  b0, b1, lb0, lb1;
  logic seen;

  initial begin
    reset_n = 1'b0; req_valid = '0; req_data = '0; ser_ready = 1'b1;
    for (int d = 0; d < 2; d++) begin
      fcount[d] = 0; lcount[d] = 0; acc[d] = '0;
      m_mode[d] = 0; m_rr[d] = 0; m_hold[d] = '0; m_src[d] = '0;
      m_pos[d] = 0; m_gap[d] = 0; m_word[d] = '0;
    end
    fork monitor(); join_none
    repeat (3) step();
    chk("rst_outputs", {req_ready, sr_load, sr_shift, sr_data_in, ser_valid, ser_last, ser_id, busy}, 32'd0);
    chk("rst_ser_bit", 32'(ser_bit), 32'd0);
    reset_n = 1'b1;

    // idle, no requests
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen = seen | (|{req_ready, sr_load, sr_shift, ser_valid, busy});
    end
    chk("idle_quiet", 32'(seen), 32'd0);

    // single word from requester 0
    b0 = fcount[0]; b1 = fcount[1];
    step();
    req_data = {8'h00, 8'hAA}; req_valid = 2'b01;
    @(negedge clk);
    chk("sw_ready", 32'(req_ready[0]), 32'h1);
    chk("sw_load", 32'(sr_load[0]), 32'h1);
    chk("sw_data", 32'(sr_data_in[0]), 32'hAA);
    step();
    req_valid = 2'b00;
    wait_idle("sw_idle");
    chk("sw_count0", fcount[0] - b0, 1);
    chk("sw_word0", 32'(fword[0][b0 % 64]), 32'hAA);
    chk("sw_id0", fid[0][b0 % 64], 0);
    chk("sw_word3", 32'(fword[1][b1 % 64]), 32'hAA);

    // backpressure on 8'hA5 from requester 1: stall while bit index 3 is shown
    b0 = fcount[0]; b1 = fcount[1];
    step();
    req_data = {8'hA5, 8'h00}; req_valid = 2'b10;
    step();
    req_valid = 2'b00;
    repeat (3) step();
    ser_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_shift", 32'(sr_shift[0]), 32'd0);
      chk("bp_bit", 32'(ser_bit[0]), 32'd0);
      chk("bp_valid_last", {30'd0, ser_valid[0], ser_last[0]}, 32'b10);
      step();
    end
    ser_ready = 1'b1;
    wait_idle("bp_idle");
    chk("bp_word0", 32'(fword[0][b0 % 64]), 32'hA5);
    chk("bp_id0", fid[0][b0 % 64], 1);
    chk("bp_word3", 32'(fword[1][b1 % 64]), 32'hA5);

    // round robin with both requesters held valid
    b0 = fcount[0]; b1 = fcount[1]; lb0 = lcount[0]; lb1 = lcount[1];
    step();
    req_data = {8'hF0, 8'h0F}; req_valid = 2'b11;
    repeat (36) step();
    req_valid = 2'b00;
    wait_idle("rr_idle");
    chk("rr_count0", fcount[0] - b0, 4);
    chk("rr_count3", fcount[1] - b1, 3);
    for (int k = 0; k < 4; k++) begin
      chk("rr_id0", fid[0][(b0 + k) % 64], k % 2);
      chk("rr_word0", 32'(fword[0][(b0 + k) % 64]), (k % 2 == 0) ? 32'h0F : 32'hF0);
    end
    for (int k = 0; k < 3; k++) chk("rr_id3", fid[1][(b1 + k) % 64], k % 2);
    for (int k = 0; k < 3; k++)
      chk("rr_period0", lcyc[0][(lb0 + k + 1) % 64] - lcyc[0][(lb0 + k) % 64], 9);
    for (int k = 0; k < 2; k++)
      chk("gap_period3", lcyc[1][(lb1 + k + 1) % 64] - lcyc[1][(lb1 + k) % 64], 12);

    // reset in the middle of a frame
    step();
    req_data = {8'h3C, 8'h96}; req_valid = 2'b10;
    step();
    req_valid = 2'b11;
    b0 = fcount[0]; b1 = fcount[1];
    repeat (3) step();
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_outputs", {req_ready, sr_load, sr_shift, sr_data_in, ser_valid, ser_last, ser_id, busy}, 32'd0);
    @(posedge clk);
    #3 reset_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_grant0", 32'(req_ready[0]), 32'h1);
    chk("mid_rst_grant3", 32'(req_ready[1]), 32'h1);
    step();
    req_valid = 2'b00;
    wait_idle("mid_rst_idle");
    chk("mid_rst_count", fcount[0] - b0, 1);
    chk("mid_rst_word", 32'(fword[0][b0 % 64]), 32'h96);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step();
      req_valid = N'($urandom);
      req_data  = (N*W)'($urandom);
      ser_ready = ($urandom_range(0, 3) != 0);
    end
    step();
    req_valid = '0;
    ser_ready = 1'b1;
    wait_idle("rand_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_register_ctrl.md
Name: shift_register_ctrl

Overview:
- Sequencer and arbiter for the 8-bit parallel-load shift register.
- Accepts parallel words from NREQ requesters over valid/ready, picks one by round-robin and drives the register's load and shift enables.
- Streams the loaded word MSB-first to a single serial sink with backpressure, and tags each frame with its source ID and a last-bit marker.
- The shift register itself stays external. This block owns only its timing and sharing.

Parameters:
- WIDTH, 8, word width; the shift register's width and bits per frame.
- NREQ, 2, number of requesters (2..8).
- GAP_CYCLES, 0, idle cycles inserted after each frame before the next grant (0..15).

Ports:
- clk  input  1  clock, all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req_valid  input  NREQ  requester i has a word.
- req_data  input  NREQ*WIDTH  word of requester i is at bits [i*WIDTH +: WIDTH].
- req_ready  output  NREQ  one-hot accept. Transfer occurs when req_valid[i] & req_ready[i].
- sr_load  output  1  parallel-load enable to the shift register.
- sr_shift  output  1  shift enable to the shift register (toward MSB, 0 shifted in).
- sr_data_in  output  WIDTH  parallel data to the shift register.
- sr_msb  input  1  current MSB of the shift register.
- ser_bit  output  1  serial data, equal to sr_msb.
- ser_valid  output  1  ser_bit is valid.
- ser_ready  input  1  sink accepts the bit.
- ser_last  output  1  current bit is the final bit of the frame.
- ser_id  output  clog2(NREQ) (min 1)  source of the current frame.
- busy  output  1  state is not IDLE.

Behaviour:
- Reset (async assert, sync release):
  - State goes to IDLE; bit_cnt=0; gap_cnt=0; rr_ptr=0 (requester 0 highest priority).
  - req_ready=0, sr_load=0, sr_shift=0, sr_data_in=0, ser_valid=0, ser_last=0, ser_id=0, busy=0.
  - Reset mid-frame abandons the frame silently; no partial ser_last is produced.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - If any req_valid is set, grant g is the first set bit scanning from rr_ptr upward, with wrap-around.
  - The grant is combinational in the same cycle: req_ready[g]=1, sr_load=1, sr_data_in=req_data[g].
  - Registered on the edge: ser_id<=g, rr_ptr<=(g+1) mod NREQ, bit_cnt<=0, state<=SHIFT.
  - If no req_valid is set: all outputs inactive, sr_data_in holds its last value, rr_ptr is unchanged.
  - req_ready is never asserted outside IDLE and is never multi-hot.
- SHIFT:
  - ser_valid=1, ser_bit=sr_msb, ser_last=(bit_cnt==WIDTH-1).
  - With ser_ready=1: sr_shift=1 and bit_cnt increments.
  - With ser_ready=0: sr_shift=0 and all state holds; ser_bit, ser_last and ser_id stay stable.
  - On an accepted bit with ser_last=1: go to GAP with gap_cnt=GAP_CYCLES-1 if GAP_CYCLES>0, else go to IDLE.
- GAP:
  - All outputs inactive; gap_cnt decrements; go to IDLE when gap_cnt==0.
- Latency and throughput:
  - First serial bit is valid the cycle after the grant.
  - Minimum frame period is WIDTH+1+GAP_CYCLES cycles (the IDLE grant cycle is always a bubble).
- bit_cnt width is clog2(WIDTH). No wrap beyond WIDTH-1 is reachable.
- A requester that drops req_valid while ungranted loses nothing; it is simply not considered.
- A requester that keeps req_valid high after its grant is re-arbitrated fairly: with all NREQ requesting, grants rotate 0,1,…,NREQ-1,0.
- busy=1 in SHIFT and GAP.

Test Plan:
- Reset then single word:
  - Stimulus: req_valid=01, req_data[7:0]=8'hAA.
  - Required response: req_ready=01 and sr_load=1 for one cycle, sr_data_in=8'hAA; then 8 ser_valid cycles carrying 1,0,1,0,1,0,1,0 MSB-first, ser_id=0; ser_last only on the 8th bit; busy back to 0 after the frame.
- Round-robin:
  - Stimulus: both requesters held valid, data 8'h0F (req0) and 8'hF0 (req1).
  - Required response: grant order 0,1,0,1 with ser_id matching; each frame takes 9 cycles with ser_ready=1.
- Backpressure:
  - Stimulus: ser_ready=0 for 3 cycles during bit 4 of 8'hA5.
  - Required response: sr_shift=0 and ser_bit, ser_last stable during the stall; total serial bits still 8 and correct (1,0,1,0,0,1,0,1).
- Gap:
  - Stimulus: GAP_CYCLES=3, back-to-back words.
  - Required response: exactly 3 inactive cycles, then 1 IDLE grant cycle between frames (frame period 12).
- Reset mid-frame:
  - Stimulus: assert reset_n=0 asynchronously after bit 3.
  - Required response: all outputs 0 immediately; after release, state is IDLE and rr_ptr=0, so requester 0 wins a simultaneous request.
- Idle / no request:
  - Stimulus: req_valid=00 for 20 cycles.
  - Required response: no req_ready, sr_load, sr_shift or ser_valid asserted; busy=0.
